edge_frame_buffer: RTL
======================

# edge_frame_buffer

Parametrised successor of the Sobel frame-buffer stage. It accepts one 3x3 luma window per cycle with its pixel coordinate and applies a run-time-selectable kernel mode: passthrough, Sobel magnitude, Sobel threshold or invert. Results are stored in an internal WIDTH×HEIGHT frame memory. Once the frame is complete, the memory streams back out in raster order over a valid/ready interface. It sits between the camera window generator and the image writer / display path.

## Interface
Parameters:
- WIDTH, 768, columns per frame
- HEIGHT, 512, rows per frame
- PIX_W, 8, bits per pixel
- IDX_W, 11, coordinate width; must satisfy 2^IDX_W > max(WIDTH, HEIGHT)
- THRESH, 100, mode-2 edge threshold, compared against unsaturated magnitude

Ports:
- CAMERA_CLK  in  1  sole clock, rising edge
- HRESETn  in  1  asynchronous, active-low reset
- mode  in  2  0 passthrough(mc), 1 Sobel magnitude, 2 Sobel threshold, 3 invert(mc); sampled only on first accepted pixel of a frame
- in_valid  in  1  window + coordinate valid
- in_ready  out  1  block accepts window this cycle
- coord_x  in  IDX_W  row index of centre pixel
- coord_y  in  IDX_W  column index of centre pixel
- win  in  9*PIX_W  packed window {ul,uc,ur,ml,mc,mr,dl,dc,dr}, ul in MSBs
- rd_start  in  1  pulse: begin raster readout (honoured only in DONE)
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  PIX_W  stored pixel, raster order
- out_last  out  1  high with final pixel (row HEIGHT-1, col WIDTH-1)
- write_done  out  1  frame fully written; held high through DONE and DRAIN
- frame_err  out  1  sticky: out-of-range coordinate seen this frame

## Operation
- States: IDLE, FILL, DONE, DRAIN.
- IDLE→FILL: on first accepted window. Mode is latched at this point.
- FILL→DONE: when the accepted-pixel counter reaches WIDTH*HEIGHT and the last pipelined write has retired.
- DONE→DRAIN: on rd_start.
- DRAIN→IDLE: on the out_last handshake.
- in_ready is 1 in IDLE and FILL, 0 in DONE and DRAIN.
- Accept occurs when in_valid && in_ready.
- Each accept increments a write counter of width ceil(lg(WIDTH*HEIGHT+1)).
  - Duplicate coordinates still count.
  - Out-of-range windows (coord_x ≥ HEIGHT or coord_y ≥ WIDTH) are dropped: no memory write, no count, and frame_err is set.
- Memory address = coord_x*WIDTH + coord_y.
- Sobel arithmetic is signed, width PIX_W+3:
  - Gx = (ur+2mr+dr) − (ul+2ml+dl)
  - Gy = (dl+2dc+dr) − (ul+2uc+ur)
  - mag = |Gx|+|Gy|, width PIX_W+4.
- Mode 1: out = min(mag, 2^PIX_W−1).
- Mode 2: out = mag ≥ THRESH ? 2^PIX_W−1 : 0.
- Mode 3: out = ~mc. Mode 0: out = mc.
- Border pixels are forced to 0 in modes 1–2. A border pixel is any with coord_x = 0, coord_x = HEIGHT−1, coord_y = 0 or coord_y = WIDTH−1.
- DRAIN reads addresses 0..WIDTH*HEIGHT−1 in order. The address advances on each out_valid && out_ready.
- out_data and out_last are held stable while out_valid && !out_ready.
- write_done and frame_err clear on the DRAIN→IDLE transition.
- rd_start outside DONE is ignored. Mode changes mid-frame are ignored.
- Memory contents are not cleared by reset or by frame restart.

## Timing
- Reset values: in_ready=0 during reset, then 1 in IDLE; out_valid=0, out_data=0, out_last=0, write_done=0, frame_err=0. State IDLE, all counters 0.
- Reset asserted mid-FILL or mid-DRAIN aborts immediately. The next frame starts fresh.
- Compute pipeline: 2 stages.
  - Window accepted at cycle N.
  - Gx/Gy registered at N+1.
  - Final pixel registered at N+2.
  - Memory written at rising edge N+3.
- write_done rises the cycle after the last memory write, i.e. 4 cycles after the final accept.
- Full throughput of one window per cycle, no bubbles.
- Memory read is synchronous, 1 cycle. The readout path keeps a 2-entry prefetch.
- First out_valid occurs 2 cycles after rd_start is sampled.
- With out_ready held high, one pixel is delivered per cycle with no gaps.
- Deasserting out_ready for k cycles stalls output exactly k cycles, with no loss or duplication.
- out_last handshake at cycle M puts the block in IDLE at M+1 with in_ready=1 and write_done=0.

## Test plan
- WIDTH=4, HEIGHT=3, mode 0, feed 12 raster windows with mc=address+10.
  - Response: write_done high 4 cycles after the 12th accept.
  - rd_start with out_ready=1 → out_data 10..21 on consecutive cycles; out_last on 21.
- Mode 1, interior window ul=ml=dl=0, ur=mr=dr=255, uc=dc=mc=0.
  - Response: Gx=1020, Gy=0, stored value 255 (saturated).
  - All border pixels read back as 0.
- Mode 2, THRESH=100, interior windows giving mag=99 and mag=100 → stored 0 and 255 respectively.
- Send coord_x=3 (≥HEIGHT) mid-frame → no count, frame_err=1. frame_err stays high until the drain completes, then clears.
- During DRAIN, toggle out_ready 1,0,0,1 → every pixel appears exactly once in order.
  - in_ready stays 0 throughout the drain.
  - rd_start pulsed in FILL has no effect.
- Assert HRESETn=0 after 5 accepts in FILL → all outputs reach reset values asynchronously.
  - After reset release, a full new frame is required before write_done rises.

Source files
------------

// File: rtl/edge_frame_buffer.sv
// 3x3 window kernel stage (passthrough / Sobel / threshold / invert) that fills a
// WIDTH x HEIGHT frame memory, then streams the frame back out in raster order.
module edge_frame_buffer #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int PIX_W  = 8,
  parameter int IDX_W  = 11,
  parameter int THRESH = 100
) (
  input  logic               CAMERA_CLK,
  input  logic               HRESETn,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   coord_x,
  input  logic [IDX_W-1:0]   coord_y,
  input  logic [9*PIX_W-1:0] win,
  input  logic               rd_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_data,
  output logic               out_last,
  output logic               write_done,
  output logic               frame_err
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int SW    = PIX_W + 3;
  localparam int MW    = PIX_W + 4;
  localparam logic [CW-1:0]    TOTAL_C = CW'(TOTAL);
  localparam logic [CW-1:0]    LAST_C  = CW'(TOTAL - 1);
  localparam logic [AW-1:0]    WIDTH_A = AW'(WIDTH);
  localparam logic [IDX_W-1:0] H_C     = IDX_W'(HEIGHT);
  localparam logic [IDX_W-1:0] W_C     = IDX_W'(WIDTH);
  localparam logic [IDX_W-1:0] HL_C    = IDX_W'(HEIGHT - 1);
  localparam logic [IDX_W-1:0] WL_C    = IDX_W'(WIDTH - 1);
  localparam logic [MW-1:0]    MAXV_C  = MW'((1 << PIX_W) - 1);
  localparam logic [MW-1:0]    THR_C   = MW'(THRESH);

  typedef enum logic [1:0] {IDLE, FILL, DONE, DRAIN} state_e;
  state_e state_q, state_d;

  logic [1:0]        mode_q;
  logic [CW-1:0]     wrCnt_q, rdCnt_q;
  logic              err_q, v0_q, v1_q, v2_q;
  logic              pend_q, pendLast_q;
  logic [1:0]        fifoCnt_q;
  logic [PIX_W-1:0]  head_q, tail_q, rdData_q;
  logic              headLast_q, tailLast_q;
  logic [9*PIX_W-1:0] win0_q;
  logic [AW-1:0]     addr0_q, addr1_q, addr2_q;
  logic              border0_q, border1_q;
  logic signed [SW-1:0] gx1_q, gy1_q;
  logic [PIX_W-1:0]  mc1_q, pix2_q;
  logic [PIX_W-1:0]  mem [TOTAL];

  logic              accept, inRange, borderC, pop, drainEnd, issue;
  logic [AW-1:0]     addrC;
  logic [2:0]        occ;
  logic [PIX_W-1:0]  p [9];
  logic signed [SW-1:0] gxC, gyC;
  logic [SW-1:0]     absX, absY;
  logic [MW-1:0]     magC;
  logic [PIX_W-1:0]  pixC;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] v);
    return signed'({3'b000, v});
  endfunction

  // Once the frame count is full, further windows are held off while the pipeline drains.
  assign in_ready = HRESETn && ((state_q == IDLE) || ((state_q == FILL) && (wrCnt_q != TOTAL_C)));
  assign accept   = in_valid && in_ready;
  assign inRange  = (coord_x < H_C) && (coord_y < W_C);
  assign borderC  = (coord_x == '0) || (coord_x == HL_C) || (coord_y == '0) || (coord_y == WL_C);
  assign addrC    = AW'(coord_x) * WIDTH_A + AW'(coord_y);

  assign out_valid  = (fifoCnt_q != 2'd0);
  assign out_data   = head_q;
  assign out_last   = headLast_q && out_valid;
  assign pop        = out_valid && out_ready;
  assign drainEnd   = pop && out_last;
  assign write_done = (state_q == DONE) || (state_q == DRAIN);
  assign frame_err  = err_q;

  assign occ   = {1'b0, fifoCnt_q} + {2'b00, pend_q} - {2'b00, pop};
  assign issue = (state_q == DRAIN) && (rdCnt_q != TOTAL_C) && (occ < 3'd2);

  always_ff @(posedge CAMERA_CLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = FILL;
      FILL:  if ((wrCnt_q == TOTAL_C) && !v0_q && !v1_q && !v2_q) state_d = DONE;
      DONE:  if (rd_start) state_d = DRAIN;
      DRAIN: if (drainEnd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CAMERA_CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_q     <= 2'd0;
      wrCnt_q    <= '0;
      err_q      <= 1'b0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      rdCnt_q    <= '0;
      pend_q     <= 1'b0;
      pendLast_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && accept) mode_q <= mode;
      if (drainEnd)                    wrCnt_q <= '0;
      else if (accept && inRange)      wrCnt_q <= wrCnt_q + CW'(1);
      if (drainEnd)                    err_q <= 1'b0;
      else if (accept && !inRange)     err_q <= 1'b1;
      v0_q <= accept && inRange;
      v1_q <= v0_q;
      v2_q <= v1_q;
      if (state_q != DRAIN) rdCnt_q <= '0;
      else if (issue)       rdCnt_q <= rdCnt_q + CW'(1);
      pend_q     <= issue;
      pendLast_q <= (rdCnt_q == LAST_C);
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) p[k] = win0_q[(8-k)*PIX_W +: PIX_W];
  end

  assign gxC  = (ext(p[2]) + (ext(p[5]) <<< 1) + ext(p[8])) - (ext(p[0]) + (ext(p[3]) <<< 1) + ext(p[6]));
  assign gyC  = (ext(p[6]) + (ext(p[7]) <<< 1) + ext(p[8])) - (ext(p[0]) + (ext(p[1]) <<< 1) + ext(p[2]));
  assign absX = gx1_q[SW-1] ? SW'(-gx1_q) : SW'(gx1_q);
  assign absY = gy1_q[SW-1] ? SW'(-gy1_q) : SW'(gy1_q);
  assign magC = MW'(absX) + MW'(absY);

  always_comb begin
    pixC = mc1_q;
    unique case (mode_q)
      2'd0: pixC = mc1_q;
      2'd1: pixC = border1_q ? '0 : ((magC > MAXV_C) ? '1 : magC[PIX_W-1:0]);
      2'd2: pixC = border1_q ? '0 : ((magC >= THR_C) ? '1 : '0);
      default: pixC = ~mc1_q;
    endcase
  end

  // Datapath stages carry no reset; the v*_q flags qualify them.
  always_ff @(posedge CAMERA_CLK) begin
    if (accept) begin
      win0_q    <= win;
      addr0_q   <= addrC;
      border0_q <= borderC;
    end
    gx1_q     <= gxC;
    gy1_q     <= gyC;
    mc1_q     <= p[4];
    addr1_q   <= addr0_q;
    border1_q <= border0_q;
    pix2_q    <= pixC;
    addr2_q   <= addr1_q;
  end

  always_ff @(posedge CAMERA_CLK) begin
    if (v2_q)  mem[addr2_q] <= pix2_q;
    if (issue) rdData_q <= mem[AW'(rdCnt_q)];
  end

  // Two-entry output buffer; the read issue rule guarantees it never overflows.
  always_ff @(posedge CAMERA_CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fifoCnt_q  <= 2'd0;
      head_q     <= '0;
      headLast_q <= 1'b0;
      tail_q     <= '0;
      tailLast_q <= 1'b0;
    end else begin
      case ({pend_q, pop})
        2'b10: begin
          if (fifoCnt_q == 2'd0) begin
            head_q     <= rdData_q;
            headLast_q <= pendLast_q;
          end else begin
            tail_q     <= rdData_q;
            tailLast_q <= pendLast_q;
          end
          fifoCnt_q <= fifoCnt_q + 2'd1;
        end
        2'b01: begin
          if (fifoCnt_q == 2'd2) begin
            head_q     <= tail_q;
            headLast_q <= tailLast_q;
          end
          fifoCnt_q <= fifoCnt_q - 2'd1;
        end
        2'b11: begin
          if (fifoCnt_q == 2'd1) begin
            head_q     <= rdData_q;
            headLast_q <= pendLast_q;
          end else begin
            head_q     <= tail_q;
            headLast_q <= tailLast_q;
            tail_q     <= rdData_q;
            tailLast_q <= pendLast_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
